seq_pattern_detector: RTL

Parametrised serial pattern detector for single-bit input streams, generalising the fixed "first 1 after 0" detector to any W-bit pattern loaded at run time. It counts matches and supports overlapping or non-overlapping detection. It sits beside the other expression/FSM exercise blocks and is driven by a bit source with a per-cycle valid strobe.

---
 rtl/seq_det_pkg.sv | 18 +
 rtl/seq_pattern_detector_sat_counter.sv | 33 +++
 rtl/seq_pattern_detector.sv | 101 ++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants for the serial pattern detector: FSM state encoding and
// overlap-mode encoding.
package seq_det_pkg;

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_HUNT  = 2'd1;
  localparam logic [1:0] ST_MATCH = 2'd2;

  localparam logic MODE_OVL  = 1'b1;
  localparam logic MODE_NOVL = 1'b0;

  typedef enum logic [1:0] {
    S_FILL  = ST_FILL,
    S_HUNT  = ST_HUNT,
    S_MATCH = ST_MATCH
  } det_state_e;

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter with clear priority; holds at all-ones instead of
// wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] val
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] val_q;

  // Count register: reset, then clear, then saturating increment
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= '0;
    end else if (clr) begin
      val_q <= '0;
    end else if (inc && (val_q != CNT_MAX)) begin
      val_q <= val_q + CNT_ONE;
    end else begin
      val_q <= val_q;
    end
  end

  assign val = val_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial W-bit pattern detector with run-time loadable pattern, overlapping or
// non-overlapping detection, one-cycle match pulse and saturating match count.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i,
  input  logic             i_valid,
  input  logic             load,
  input  logic [W-1:0]     pattern,
  input  logic             overlap,
  input  logic             clr_count,
  output logic             q,
  output logic [CNT_W-1:0] count,
  output logic             armed
);

  localparam int FW = $clog2(W + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(W);
  localparam logic [FW-1:0] FILL_ONE  = FW'(1);

  // Only the newest W-1 bits need storing: the incoming bit completes the window.
  logic [W-2:0] hist_q;
  logic [W-1:0] hist_d;
  logic [W-1:0] pat_q;
  logic         ovl_q;
  logic [FW-1:0] fill_q, fill_d;
  logic         q_q;
  logic         accept_s, match_s;
  det_state_e   state_q;

  // Post-shift window and fill level for the bit offered this cycle
  always_comb begin
    accept_s = i_valid & ~load;
    hist_d   = {hist_q, i};
    if (fill_q == FILL_FULL) begin
      fill_d = FILL_FULL;
    end else begin
      fill_d = fill_q + FILL_ONE;
    end
    match_s = accept_s && (fill_d == FILL_FULL) && (hist_d == pat_q);
  end

  // Detector FSM: history, fill level, mode/pattern latch and match pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= {W{1'b1}};
      ovl_q   <= MODE_OVL;
      hist_q  <= '0;
      fill_q  <= '0;
      q_q     <= 1'b0;
      state_q <= S_FILL;
    end else if (load) begin
      pat_q   <= pattern;
      ovl_q   <= overlap;
      hist_q  <= '0;
      fill_q  <= '0;
      q_q     <= 1'b0;
      state_q <= S_FILL;
    end else if (accept_s) begin
      q_q <= match_s;
      if (match_s && (ovl_q == MODE_NOVL)) begin
        hist_q <= '0;
        fill_q <= '0;
      end else begin
        hist_q <= hist_d[W-2:0];
        fill_q <= fill_d;
      end
      if (match_s) begin
        state_q <= S_MATCH;
      end else if (fill_d == FILL_FULL) begin
        state_q <= S_HUNT;
      end else begin
        state_q <= S_FILL;
      end
    end else begin
      q_q <= 1'b0;
      if (state_q == S_MATCH) begin
        state_q <= (ovl_q == MODE_NOVL) ? S_FILL : S_HUNT;
      end else begin
        state_q <= state_q;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match_s),
    .clr   (clr_count),
    .val   (count)
  );

  assign q     = q_q;
  assign armed = (fill_q == FILL_FULL);

endmodule
